// File: rtl/seg_display_mux_if.sv
// Bundle between the game FSM and the seven-segment scanner.
// The master modport is the game side; the slave modport is the display driver.
interface seg_display_mux_if #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned COUNT_W    = 8
);
  logic [2:0]            gameState_d;
  logic                  numGamesPlayedState_d;
  logic [COUNT_W-1:0]    numGamesPlayed_d;
  logic                  blink_en_d;
  logic [NUM_DIGITS-1:0] an_d;
  logic [7:0]            seg_d;
  logic                  bcd_busy_d;

  modport master (
    output gameState_d,
    output numGamesPlayedState_d,
    output numGamesPlayed_d,
    output blink_en_d,
    input  an_d,
    input  seg_d,
    input  bcd_busy_d
  );

  modport slave (
    input  gameState_d,
    input  numGamesPlayedState_d,
    input  numGamesPlayed_d,
    input  blink_en_d,
    output an_d,
    output seg_d,
    output bcd_busy_d
  );
endinterface

// File: rtl/seg_display_mux.sv
// Multiplexed common-anode seven-segment driver: game-over messages with optional blink,
// or the games-played count converted to BCD by a sequential double-dabble engine.
module seg_display_mux #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned COUNT_W      = 8,
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input logic              clk_d,
  input logic              rst_n_d,
  seg_display_mux_if.slave bus
);

  localparam int unsigned NumBcd = (COUNT_W + 2) / 3 + 1;
  localparam int unsigned BcdW   = 4 * NumBcd;
  localparam int unsigned SrW    = BcdW + COUNT_W;
  localparam int unsigned PreW   = $clog2(REFRESH_DIV);
  localparam int unsigned IdxW   = $clog2(NUM_DIGITS);
  localparam int unsigned FrmW   = $clog2(BLINK_FRAMES + 1);
  localparam int unsigned ShW    = $clog2(COUNT_W + 1);

  typedef enum logic [0:0] {StIdle, StConv} conv_st_e;

  conv_st_e               state_q, state_d;
  logic [PreW-1:0]        presc_q, presc_d;
  logic [IdxW-1:0]        idx_q, idx_d;
  logic [FrmW-1:0]        frame_q, frame_d;
  logic                   phase_q, phase_d;
  logic [COUNT_W-1:0]     cnt_q, cnt_d;
  logic [SrW-1:0]         sr_q, sr_d, sr_adj;
  logic [ShW-1:0]         sh_q, sh_d;
  logic [BcdW-1:0]        disp_q, disp_d;
  logic [NUM_DIGITS-1:0]  an_q, an_d;
  logic [7:0]             seg_q, seg_d;
  logic                   busy;
  logic                   start, last_shift, presc_last, idx_last, blink_on;
  logic [3:0]             digit;
  logic                   nz_above, ovf;
  logic [7:0]             count_glyph, src_glyph;

  function automatic logic [7:0] dec_glyph(input logic [3:0] d);
    case (d)
      4'd0: dec_glyph = 8'hC0;
      4'd1: dec_glyph = 8'hF9;
      4'd2: dec_glyph = 8'hA4;
      4'd3: dec_glyph = 8'hB0;
      4'd4: dec_glyph = 8'h99;
      4'd5: dec_glyph = 8'h92;
      4'd6: dec_glyph = 8'h82;
      4'd7: dec_glyph = 8'hF8;
      4'd8: dec_glyph = 8'h80;
      4'd9: dec_glyph = 8'h90;
      default: dec_glyph = 8'hFF;
    endcase
  endfunction

  // Digit 0 is rightmost, so messages read d-r-A-W / P-2-L / P-1-L from digit 3 down.
  function automatic logic [7:0] msg_glyph(input logic [2:0] gs, input logic [IdxW-1:0] idx);
    logic [1:0] i2;
    i2 = idx[1:0];
    msg_glyph = 8'hFF;
    if (32'(idx) < 32'd4) begin
      case (gs)
        3'd2: msg_glyph = (i2 == 2'd3) ? 8'hA1 : (i2 == 2'd2) ? 8'hAF :
                          (i2 == 2'd1) ? 8'h88 : 8'hD5;
        3'd3: msg_glyph = (i2 == 2'd3) ? 8'h8C : (i2 == 2'd2) ? 8'hA4 :
                          (i2 == 2'd1) ? 8'hC7 : 8'hFF;
        3'd4: msg_glyph = (i2 == 2'd3) ? 8'h8C : (i2 == 2'd2) ? 8'hF9 :
                          (i2 == 2'd1) ? 8'hC7 : 8'hFF;
        default: msg_glyph = 8'hFF;
      endcase
    end
  endfunction

  // Conversion engine FSM: state register, next state, outputs.
  always_ff @(posedge clk_d) begin
    if (!rst_n_d) state_q <= StIdle;
    else          state_q <= state_d;
  end

  assign start      = (state_q == StIdle) && (bus.numGamesPlayed_d != cnt_q);
  assign last_shift = (sh_q == ShW'(COUNT_W - 1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start)      state_d = StConv;
      StConv: if (last_shift) state_d = StIdle;
    endcase
  end

  always_comb begin
    busy = (state_q == StConv);
  end

  always_comb begin
    sr_adj = sr_q;
    for (int unsigned k = 0; k < NumBcd; k++) begin
      if (sr_q[COUNT_W + 4*k +: 4] >= 4'd5) begin
        sr_adj[COUNT_W + 4*k +: 4] = sr_q[COUNT_W + 4*k +: 4] + 4'd3;
      end
    end
    cnt_d  = cnt_q;
    sr_d   = sr_q;
    sh_d   = sh_q;
    disp_d = disp_q;
    if (start) begin
      cnt_d = bus.numGamesPlayed_d;
      sr_d  = SrW'(bus.numGamesPlayed_d);
      sh_d  = '0;
    end else if (busy) begin
      sr_d = {sr_adj[SrW-2:0], 1'b0};
      sh_d = sh_q + ShW'(1);
      if (last_shift) disp_d = sr_d[SrW-1 -: BcdW];
    end
  end

  // Scan timing and blink phase.
  assign presc_last = (presc_q == PreW'(REFRESH_DIV - 1));
  assign idx_last   = (idx_q == IdxW'(NUM_DIGITS - 1));
  assign blink_on   = bus.blink_en_d && (bus.gameState_d >= 3'd2) && (bus.gameState_d <= 3'd4);

  always_comb begin
    presc_d = presc_last ? '0 : presc_q + PreW'(1);
    idx_d   = idx_q;
    if (presc_last) idx_d = idx_last ? '0 : idx_q + IdxW'(1);
    frame_d = frame_q;
    phase_d = phase_q;
    if (!blink_on) begin
      frame_d = '0;
      phase_d = 1'b0;
    end else if (presc_last && idx_last) begin
      if (frame_q == FrmW'(BLINK_FRAMES - 1)) begin
        frame_d = '0;
        phase_d = ~phase_q;
      end else begin
        frame_d = frame_q + FrmW'(1);
      end
    end
  end

  // Reads disp_d so a finished conversion reaches seg on the same edge busy drops.
  always_comb begin
    digit    = 4'd0;
    nz_above = 1'b0;
    ovf      = 1'b0;
    for (int unsigned k = 0; k < NumBcd; k++) begin
      if (k == 32'(idx_q)) digit = disp_d[4*k +: 4];
      if (k >= 32'(idx_q) && disp_d[4*k +: 4] != 4'd0) nz_above = 1'b1;
      if (k >= NUM_DIGITS && disp_d[4*k +: 4] != 4'd0) ovf = 1'b1;
    end
    if (ovf)                             count_glyph = 8'hBF;
    else if (nz_above || idx_q == '0)    count_glyph = dec_glyph(digit);
    else                                 count_glyph = 8'hFF;
  end

  always_comb begin
    case (bus.gameState_d)
      3'd2, 3'd3, 3'd4: src_glyph = msg_glyph(bus.gameState_d, idx_q);
      3'd0, 3'd1:       src_glyph = bus.numGamesPlayedState_d ? count_glyph : 8'hFF;
      default:          src_glyph = 8'hFF;
    endcase
    seg_d = (blink_on && phase_q) ? 8'hFF : src_glyph;
    an_d  = ~(NUM_DIGITS'(1) << idx_q);
  end

  always_ff @(posedge clk_d) begin
    if (!rst_n_d) begin
      presc_q <= '0;
      idx_q   <= '0;
      frame_q <= '0;
      phase_q <= 1'b0;
      cnt_q   <= '0;
      sr_q    <= '0;
      sh_q    <= '0;
      disp_q  <= '0;
      an_q    <= '1;
      seg_q   <= 8'hFF;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      frame_q <= frame_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      sh_q    <= sh_d;
      disp_q  <= disp_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign bus.an_d       = an_q;
  assign bus.seg_d      = seg_q;
  assign bus.bcd_busy_d = busy;

endmodule
